// File: rtl/fifo_param_if.sv
// ---------------------------------------------------------------------------
// fifo_param_if
// Bundles the producer/consumer side of fifo_param.
//   master : the user side. It drives the write data, the wr/rd requests,
//            the thresholds and err_clr, and it observes the FIFO outputs.
//   slave  : the FIFO itself.
// Signals:
//   Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo, err_clr  (to FIFO)
//   Fifo_Data_out, valid_read, Fifo_full, Fifo_empty, almost_full,
//   almost_empty, Fifo_count, Fifo_rd_error, Fifo_wr_error, Fifo_error (from FIFO)
// ---------------------------------------------------------------------------
interface fifo_param_if #(
   parameter int BITNUMBER = 6,
   parameter int LENGTH    = 4,
   parameter int PTRW      = $clog2(LENGTH)
);
   logic [BITNUMBER-1:0] Fifo_Data_in;
   logic                 Fifo_wr;
   logic                 Fifo_rd;
   logic [PTRW:0]        umbral_alto;
   logic [PTRW:0]        umbral_bajo;
   logic                 err_clr;
   logic [BITNUMBER-1:0] Fifo_Data_out;
   logic                 valid_read;
   logic                 Fifo_full;
   logic                 Fifo_empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [PTRW:0]        Fifo_count;
   logic                 Fifo_rd_error;
   logic                 Fifo_wr_error;
   logic                 Fifo_error;

   modport master (
      output Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo, err_clr,
      input  Fifo_Data_out, valid_read, Fifo_full, Fifo_empty, almost_full,
             almost_empty, Fifo_count, Fifo_rd_error, Fifo_wr_error, Fifo_error
   );

   modport slave (
      input  Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo, err_clr,
      output Fifo_Data_out, valid_read, Fifo_full, Fifo_empty, almost_full,
             almost_empty, Fifo_count, Fifo_rd_error, Fifo_wr_error, Fifo_error
   );
endinterface

// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parametrised synchronous FIFO. It provides programmable almost-full and
// almost-empty thresholds, an occupancy count, one-cycle rd/wr error pulses
// and a sticky error flag that is cleared with err_clr.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    fifo_param_if.slave (data, requests, thresholds, flags, errors)
// Read data is registered, so it arrives one cycle after the request and
// valid_read marks that cycle. The status flags are combinational from the
// registered count and the live threshold inputs.
// ---------------------------------------------------------------------------
module fifo_param #(
   parameter int BITNUMBER = 6,
   parameter int LENGTH    = 4,
   parameter int PTRW      = $clog2(LENGTH)
) (
   input  logic        clk,
   input  logic        reset,
   fifo_param_if.slave bus
);

   localparam logic [PTRW:0]   DEPTH_C   = (PTRW+1)'(LENGTH);
   localparam logic [PTRW:0]   CNT_ONE_C = (PTRW+1)'(1);
   localparam logic [PTRW-1:0] PTR_ONE_C = PTRW'(1);

   logic [BITNUMBER-1:0] mem_r [LENGTH];
   logic [PTRW-1:0]      wr_ptr_r;
   logic [PTRW-1:0]      rd_ptr_r;
   logic [PTRW:0]        count_r;
   logic [BITNUMBER-1:0] data_out_r;
   logic                 valid_read_r;
   logic                 rd_error_r;
   logic                 wr_error_r;
   logic                 error_r;

   logic                 full_s;
   logic                 empty_s;
   logic                 rd_accept_s;
   logic                 wr_accept_s;
   logic                 rd_reject_s;
   logic                 wr_reject_s;
   logic [PTRW:0]        count_next_s;
   logic                 error_next_s;

   // Acceptance decisions use the count before the edge. When the FIFO is
   // full, a simultaneous read frees the slot that the write then uses.
   always_comb begin
      full_s       = (count_r == DEPTH_C);
      empty_s      = (count_r == {(PTRW+1){1'b0}});
      rd_accept_s  = bus.Fifo_rd & ~empty_s;
      rd_reject_s  = bus.Fifo_rd & empty_s;
      wr_accept_s  = bus.Fifo_wr & (~full_s | bus.Fifo_rd);
      wr_reject_s  = bus.Fifo_wr & full_s & ~bus.Fifo_rd;
      count_next_s = count_r;
      case ({wr_accept_s, rd_accept_s})
         2'b10:   count_next_s = count_r + CNT_ONE_C;
         2'b01:   count_next_s = count_r - CNT_ONE_C;
         default: count_next_s = count_r;
      endcase
      // A new error wins over a coincident clear.
      error_next_s = error_r;
      if (rd_reject_s || wr_reject_s) begin
         error_next_s = 1'b1;
      end else if (bus.err_clr) begin
         error_next_s = 1'b0;
      end else begin
         error_next_s = error_r;
      end
   end

   // Storage array. It has no reset because its contents are don't-care
   // after reset.
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_r[wr_ptr_r] <= bus.Fifo_Data_in;
      end
   end

   // Pointers, occupancy, read data and error state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r     <= {PTRW{1'b0}};
         rd_ptr_r     <= {PTRW{1'b0}};
         count_r      <= {(PTRW+1){1'b0}};
         data_out_r   <= {BITNUMBER{1'b0}};
         valid_read_r <= 1'b0;
         rd_error_r   <= 1'b0;
         wr_error_r   <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         if (wr_accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (rd_accept_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
            data_out_r <= mem_r[rd_ptr_r];
         end
         count_r      <= count_next_s;
         valid_read_r <= rd_accept_s;
         rd_error_r   <= rd_reject_s;
         wr_error_r   <= wr_reject_s;
         error_r      <= error_next_s;
      end
   end

   assign bus.Fifo_Data_out = data_out_r;
   assign bus.valid_read    = valid_read_r;
   assign bus.Fifo_count    = count_r;
   assign bus.Fifo_full     = full_s;
   assign bus.Fifo_empty    = empty_s;
   assign bus.almost_full   = (count_r >= bus.umbral_alto);
   assign bus.almost_empty  = (count_r <= bus.umbral_bajo);
   assign bus.Fifo_rd_error = rd_error_r;
   assign bus.Fifo_wr_error = wr_error_r;
   assign bus.Fifo_error    = error_r;

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Directed bench for fifo_param with BITNUMBER=6 and LENGTH=4. A queue-based
// reference model tracks the expected contents and outputs. It is compared
// against the DUT on every falling edge, and hand-computed literal
// expectations are checked at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_fifo_param;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   bit   chk_en;

   fifo_param_if #(.BITNUMBER(6), .LENGTH(4)) bus ();

   fifo_param #(.BITNUMBER(6), .LENGTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a FIFO holding at most 4 words.
   logic [5:0] q[$];
   logic [5:0] m_dout  = 6'h00;
   logic       m_valid = 1'b0;
   logic       m_rderr = 1'b0;
   logic       m_wrerr = 1'b0;
   logic       m_err   = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_dout  <= 6'h00;
         m_valid <= 1'b0;
         m_rderr <= 1'b0;
         m_wrerr <= 1'b0;
         m_err   <= 1'b0;
      end else begin
         m_rderr <= bus.Fifo_rd && (q.size() == 0);
         m_wrerr <= bus.Fifo_wr && !bus.Fifo_rd && (q.size() == 4);
         m_err   <= (bus.Fifo_rd && (q.size() == 0)) ||
                    (bus.Fifo_wr && !bus.Fifo_rd && (q.size() == 4)) ||
                    (m_err && !bus.err_clr);
         if (bus.Fifo_rd && (q.size() != 0)) begin
            m_dout  <= q.pop_front();
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
         if (bus.Fifo_wr && (q.size() < 4)) begin
            q.push_back(bus.Fifo_Data_in);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_count",   32'(bus.Fifo_count),    32'(q.size()));
         check("m_full",    32'(bus.Fifo_full),     32'(q.size() == 4));
         check("m_empty",   32'(bus.Fifo_empty),    32'(q.size() == 0));
         check("m_afull",   32'(bus.almost_full),   32'(q.size() >= int'(bus.umbral_alto)));
         check("m_aempty",  32'(bus.almost_empty),  32'(q.size() <= int'(bus.umbral_bajo)));
         check("m_dout",    32'(bus.Fifo_Data_out), 32'(m_dout));
         check("m_valid",   32'(bus.valid_read),    32'(m_valid));
         check("m_rderr",   32'(bus.Fifo_rd_error), 32'(m_rderr));
         check("m_wrerr",   32'(bus.Fifo_wr_error), 32'(m_wrerr));
         check("m_err",     32'(bus.Fifo_error),    32'(m_err));
      end
   end

   // Drive one cycle of requests, then return the inputs to idle.
   task automatic cyc(input logic wr, input logic rd, input logic [5:0] din, input logic clr);
      bus.Fifo_wr      = wr;
      bus.Fifo_rd      = rd;
      bus.Fifo_Data_in = din;
      bus.err_clr      = clr;
      @(posedge clk);
      #1;
      bus.Fifo_wr = 1'b0;
      bus.Fifo_rd = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      chk_en           = 1'b0;
      reset            = 1'b1;
      bus.Fifo_wr      = 1'b0;
      bus.Fifo_rd      = 1'b0;
      bus.Fifo_Data_in = 6'h00;
      bus.err_clr      = 1'b0;
      bus.umbral_alto  = 3'd3;
      bus.umbral_bajo  = 3'd1;
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;

      // Reset state
      #6;
      check("rst_empty",  32'(bus.Fifo_empty),    32'd1);
      check("rst_aempty", 32'(bus.almost_empty),  32'd1);
      check("rst_full",   32'(bus.Fifo_full),     32'd0);
      check("rst_afull",  32'(bus.almost_full),   32'd0);
      check("rst_count",  32'(bus.Fifo_count),    32'd0);
      check("rst_dout",   32'(bus.Fifo_Data_out), 32'h00);
      check("rst_err",    32'(bus.Fifo_error),    32'd0);
      #4 reset = 1'b1;
      @(negedge clk);

      // Fill the FIFO
      cyc(1'b1, 1'b0, 6'h11, 1'b0);
      cyc(1'b1, 1'b0, 6'h22, 1'b0);
      @(negedge clk);
      check("fill2_afull", 32'(bus.almost_full), 32'd0);
      cyc(1'b1, 1'b0, 6'h33, 1'b0);
      @(negedge clk);
      check("fill3_afull", 32'(bus.almost_full), 32'd1);
      check("fill3_count", 32'(bus.Fifo_count),  32'd3);
      cyc(1'b1, 1'b0, 6'h3F, 1'b0);
      @(negedge clk);
      check("fill4_full",  32'(bus.Fifo_full),   32'd1);
      check("fill4_count", 32'(bus.Fifo_count),  32'd4);

      // Write while full is rejected
      cyc(1'b1, 1'b0, 6'h05, 1'b0);
      @(negedge clk);
      check("ovf_wrerr", 32'(bus.Fifo_wr_error), 32'd1);
      check("ovf_err",   32'(bus.Fifo_error),    32'd1);
      check("ovf_count", 32'(bus.Fifo_count),    32'd4);
      cyc(1'b0, 1'b0, 6'h00, 1'b0);
      @(negedge clk);
      check("ovf_pulse", 32'(bus.Fifo_wr_error), 32'd0);
      check("ovf_stick", 32'(bus.Fifo_error),    32'd1);

      // Simultaneous read and write while full
      cyc(1'b1, 1'b1, 6'h2A, 1'b0);
      @(negedge clk);
      check("rw_dout",  32'(bus.Fifo_Data_out), 32'h11);
      check("rw_valid", 32'(bus.valid_read),    32'd1);
      check("rw_count", 32'(bus.Fifo_count),    32'd4);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("rd_22", 32'(bus.Fifo_Data_out), 32'h22);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("rd_33", 32'(bus.Fifo_Data_out), 32'h33);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("rd_3F", 32'(bus.Fifo_Data_out), 32'h3F);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("rd_2A",    32'(bus.Fifo_Data_out), 32'h2A);
      check("rd_empty", 32'(bus.Fifo_empty),    32'd1);
      cyc(1'b0, 1'b0, 6'h00, 1'b0);
      @(negedge clk);
      check("idle_valid", 32'(bus.valid_read),    32'd0);
      check("idle_hold",  32'(bus.Fifo_Data_out), 32'h2A);

      // Read and write while empty: the read is rejected and there is no bypass
      cyc(1'b1, 1'b1, 6'h07, 1'b0);
      @(negedge clk);
      check("emp_rderr", 32'(bus.Fifo_rd_error), 32'd1);
      check("emp_valid", 32'(bus.valid_read),    32'd0);
      check("emp_count", 32'(bus.Fifo_count),    32'd1);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("emp_rd07", 32'(bus.Fifo_Data_out), 32'h07);

      // Sticky clear, and a new error winning over a coincident clear
      cyc(1'b0, 1'b0, 6'h00, 1'b1);
      @(negedge clk);
      check("clr_err", 32'(bus.Fifo_error), 32'd0);
      cyc(1'b0, 1'b1, 6'h00, 1'b1);
      @(negedge clk);
      check("clr_set_wins", 32'(bus.Fifo_error), 32'd1);
      cyc(1'b0, 1'b0, 6'h00, 1'b1);

      // Asynchronous reset in the middle of a stream
      cyc(1'b1, 1'b0, 6'h01, 1'b0);
      cyc(1'b1, 1'b0, 6'h02, 1'b0);
      cyc(1'b1, 1'b0, 6'h03, 1'b0);
      cyc(1'b1, 1'b0, 6'h04, 1'b0);
      cyc(1'b1, 1'b0, 6'h05, 1'b0);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("pre_count", 32'(bus.Fifo_count), 32'd3);
      check("pre_valid", 32'(bus.valid_read), 32'd1);
      check("pre_err",   32'(bus.Fifo_error), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("ar_count", 32'(bus.Fifo_count),    32'd0);
      check("ar_valid", 32'(bus.valid_read),    32'd0);
      check("ar_err",   32'(bus.Fifo_error),    32'd0);
      check("ar_wrerr", 32'(bus.Fifo_wr_error), 32'd0);
      check("ar_empty", 32'(bus.Fifo_empty),    32'd1);
      @(negedge clk);
      #1 reset = 1'b1;
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      @(negedge clk);
      check("ar_rderr", 32'(bus.Fifo_rd_error), 32'd1);

      // Threshold changes take effect in the same cycle
      bus.umbral_bajo = 3'd0;
      #1;
      check("bajo0_c0", 32'(bus.almost_empty), 32'd1);
      cyc(1'b1, 1'b0, 6'h15, 1'b0);
      @(negedge clk);
      check("bajo0_c1", 32'(bus.almost_empty), 32'd0);
      bus.umbral_alto = 3'd0;
      #1;
      check("alto0_c1", 32'(bus.almost_full), 32'd1);
      bus.umbral_alto = 3'd7;
      cyc(1'b1, 1'b0, 6'h16, 1'b0);
      cyc(1'b1, 1'b0, 6'h17, 1'b0);
      cyc(1'b1, 1'b0, 6'h18, 1'b0);
      @(negedge clk);
      check("alto7_full",  32'(bus.Fifo_full),   32'd1);
      check("alto7_afull", 32'(bus.almost_full), 32'd0);
      cyc(1'b0, 1'b1, 6'h00, 1'b0);
      cyc(1'b0, 1'b0, 6'h00, 1'b0);
      @(negedge clk);
      check("tail_dout", 32'(bus.Fifo_Data_out), 32'h15);

      #2;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
